// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder: opcode encoding, default sizing,
// and the chunk-width calculation used to split the datapath into equal ripple stages.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_BITS   = 32;
    localparam int DEF_STAGES = 4;

    function automatic int chunk_width(input int bits, input int stages);
        return (stages > 0) ? bits / stages : bits;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// W-bit combinational ripple-carry chain of full_adder cells; one chunk per pipeline stage.
// Purely combinational: no latency, no flow control.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .sum  (sum[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[W];
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of each ripple chunk.
// Purely combinational: no latency, no flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_pipe_n.sv
// Pipelined BITS-wide add/subtract split into STAGES ripple chunks with registered carries; latency STAGES.
// Whole pipe advances together: in_ready = ~out_valid | out_ready. ADDER_PIPE_FLAGS_EN builds overflow/zero.
module adder_pipe_n
    import adder_pkg::*;
#(
    parameter int BITS   = DEF_BITS,
    parameter int STAGES = DEF_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] Sum,
    output logic            cout,
    output logic            overflow,
    output logic            zero
);
    localparam int W = chunk_width(BITS, STAGES);

    if (STAGES < 1 || STAGES > BITS || (BITS % STAGES) != 0) begin : g_bad_cfg
        $error("adder_pipe_n: need 1 <= STAGES <= BITS and BITS a multiple of STAGES");
    end

    logic            w_adv;
    logic [BITS-1:0] w_beff;
    logic            w_cin_eff;

    assign w_beff    = (sub == OP_ADD) ? B : ~B;
    assign w_cin_eff = (sub == OP_SUB) ? 1'b1 : cin;

    // Stage k adds chunk k; its register carries the finished low sum bits plus the untouched high operand bits.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * W;
        localparam int HI = LO + W - 1;

        logic [W-1:0] w_ca;
        logic [W-1:0] w_cb;
        logic [W-1:0] w_cs;
        logic         w_ci;
        logic         w_co;
        logic         w_vld_in;
        logic [HI:0]  w_sum_nxt;
        logic         r_vld;
        logic         r_c;
        logic [HI:0]  r_sum;

        if (k == 0) begin : g_src
            assign w_ca      = A[HI:LO];
            assign w_cb      = w_beff[HI:LO];
            assign w_ci      = w_cin_eff;
            assign w_vld_in  = in_valid;
            assign w_sum_nxt = w_cs;
        end else begin : g_src
            assign w_ca      = g_stg[k-1].g_skew.r_a[HI:LO];
            assign w_cb      = g_stg[k-1].g_skew.r_b[HI:LO];
            assign w_ci      = g_stg[k-1].r_c;
            assign w_vld_in  = g_stg[k-1].r_vld;
            assign w_sum_nxt = {w_cs, g_stg[k-1].r_sum};
        end

        adder_chunk #(.W(W)) u_chunk (
            .a    (w_ca),
            .b    (w_cb),
            .cin  (w_ci),
            .sum  (w_cs),
            .cout (w_co)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_adv) begin
                r_vld <= w_vld_in;
                r_c   <= w_co;
                r_sum <= w_sum_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [BITS-1:HI+1] w_a_nxt;
            logic [BITS-1:HI+1] w_b_nxt;
            logic [BITS-1:HI+1] r_a;
            logic [BITS-1:HI+1] r_b;

            if (k == 0) begin : g_from
                assign w_a_nxt = A[BITS-1:HI+1];
                assign w_b_nxt = w_beff[BITS-1:HI+1];
            end else begin : g_from
                assign w_a_nxt = g_stg[k-1].g_skew.r_a[BITS-1:HI+1];
                assign w_b_nxt = g_stg[k-1].g_skew.r_b[BITS-1:HI+1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_nxt;
                    r_b <= w_b_nxt;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].r_vld;
    assign Sum       = g_stg[STAGES-1].r_sum;
    assign cout      = g_stg[STAGES-1].r_c;
    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;

`ifdef ADDER_PIPE_FLAGS_EN
    logic w_c_msb;
    logic r_ovf;
    logic r_zero;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    assign w_c_msb = g_stg[STAGES-1].w_cs[W-1] ^ g_stg[STAGES-1].w_ca[W-1] ^ g_stg[STAGES-1].w_cb[W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            r_ovf  <= w_c_msb ^ g_stg[STAGES-1].w_co;
            r_zero <= ~|g_stg[STAGES-1].w_sum_nxt;
        end
    end

    assign overflow = r_ovf;
    assign zero     = r_zero;
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule
